clock_divider_rtl: RTL and testbench



---
 rtl/clock_divider_pkg.sv | 13 +
 rtl/clock_divider_negedge_stage.sv | 24 ++
 rtl/clock_divider_rtl.sv | 65 ++++++
 tb/tb_clock_divider_rtl.sv | 129 ++++++++++++
 4 files changed

// File: rtl/clock_divider_pkg.sv
// Shared types and helpers for the integer clock divider.
package clock_divider_pkg;

    localparam int CNT_W = 28;

    typedef logic [CNT_W-1:0] div_cnt_t;

    // Length of the low phase: the divided clock is high once cnt reaches this value.
    function automatic div_cnt_t div_half(div_cnt_t d);
        return d >> 1;
    endfunction

endpackage

// File: rtl/clock_divider_negedge_stage.sv
// Half-cycle stage for odd divisors: re-times the posedge clock onto the falling
// edge and ANDs both copies, so the rise slips by half a period and the fall stays put.
module clock_divider_negedge_stage (
    input  logic clock_in,
    input  logic rst,
    input  logic enable,
    input  logic q_pos,
    output logic clock_out
);

    logic q_neg;

    always_ff @(negedge clock_in or posedge rst) begin
        if (rst) begin
            q_neg <= 1'b0;
        end else if (enable) begin
            q_neg <= q_pos;
        end
    end

    // Both inputs are flops clocked on opposite edges, so the AND cannot glitch.
    assign clock_out = q_pos & q_neg;

endmodule

// File: rtl/clock_divider_rtl.sv
// Integer clock divider with a rising-edge tick and a debug phase counter.
// Define CLOCK_DIVIDER_ODD_DUTY_EN to get 50 % duty for odd divisors.
module clock_divider_rtl
    import clock_divider_pkg::*;
#(
    parameter div_cnt_t DIVISOR = 28'd2
) (
    input  logic           clock_in,
    input  logic           rst,
    input  logic           enable,
    output logic           clock_out,
    output logic           tick,
    output logic [CNT_W-1:0] count
);

    localparam div_cnt_t HALF = div_half(DIVISOR);
    localparam div_cnt_t TERM = DIVISOR - div_cnt_t'(1);

    if (DIVISOR < div_cnt_t'(2)) begin : g_bad_divisor
        $error("clock_divider_rtl: DIVISOR must be at least 2");
    end

    div_cnt_t cnt;
    div_cnt_t cnt_next;
    logic     q_pos;

    always_comb begin
        cnt_next = cnt;
        if (enable) begin
            cnt_next = (cnt == TERM) ? '0 : cnt + div_cnt_t'(1);
        end
    end

    // Output and tick come from cnt_next so both are plain flop outputs.
    always_ff @(posedge clock_in or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            q_pos <= 1'b0;
            tick  <= 1'b0;
        end else begin
            cnt   <= cnt_next;
            q_pos <= (cnt_next >= HALF);
            tick  <= enable & (cnt_next == HALF);
        end
    end

    assign count = cnt;

`ifdef CLOCK_DIVIDER_ODD_DUTY_EN
    if (DIVISOR[0]) begin : g_odd_duty
        clock_divider_negedge_stage u_negedge_stage (
            .clock_in  (clock_in),
            .rst       (rst),
            .enable    (enable),
            .q_pos     (q_pos),
            .clock_out (clock_out)
        );
    end else begin : g_even_duty
        assign clock_out = q_pos;
    end
`else
    assign clock_out = q_pos;
`endif

endmodule

// File: tb/tb_clock_divider_rtl.sv
// Self-checking bench: four dividers (2, 4, 5, 16) on one clock, checked each cycle
// against a phase model built from the count of enabled edges since reset.
module tb_clock_divider_rtl;

    localparam int NDUT = 4;
    localparam int DIVS [NDUT] = '{2, 4, 5, 16};

    logic        clk;
    logic        rst;
    logic        enable;
    logic        co [NDUT];
    logic        tk [NDUT];
    logic [27:0] cn [NDUT];

    int n_cmp;
    int n_bad;

    // model state: enabled edges since reset, and model clock level after last edge
    int unsigned edges [NDUT];
    bit          hi    [NDUT];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        clock_divider_rtl #(.DIVISOR(28'(DIVS[g]))) u_dut (
            .clock_in  (clk),
            .rst       (rst),
            .enable    (enable),
            .clock_out (co[g]),
            .tick      (tk[g]),
            .count     (cn[g])
        );
    end

    task automatic check(input string tag, input int k, input logic [27:0] obs, input logic [27:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $display("FAIL %s div=%0d t=%0t observed=%0d expected=%0d", tag, DIVS[k], $time, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic check_all(input bit [NDUT-1:0] exp_tick, input bit [NDUT-1:0] exp_clk);
        for (int k = 0; k < NDUT; k++) begin
            check("count", k, cn[k], 28'(edges[k] % DIVS[k]));
            check("clock_out", k, 28'(co[k]), 28'(exp_clk[k]));
            check("tick", k, 28'(tk[k]), 28'(exp_tick[k]));
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NDUT; k++) begin
            edges[k] = 0;
            hi[k]    = 1'b0;
        end
    endtask

    // One clock_in cycle: drive enable at the falling edge, sample just after the rising edge.
    task automatic step(input bit en);
        bit [NDUT-1:0] etick;
        bit [NDUT-1:0] eclk;
        bit            prev;
        @(negedge clk);
        enable = en;
        @(posedge clk);
        #1;
        for (int k = 0; k < NDUT; k++) begin
            prev = hi[k];
            if (en) edges[k]++;
            hi[k]    = (edges[k] % DIVS[k]) >= (DIVS[k] / 2);
            etick[k] = !prev && hi[k];
`ifdef CLOCK_DIVIDER_ODD_DUTY_EN
            eclk[k]  = (DIVS[k] % 2 == 1) ? (hi[k] && prev) : hi[k];
`else
            eclk[k]  = hi[k];
`endif
        end
        check_all(etick, eclk);
    endtask

    // Assert reset between edges and check outputs clear without any clock edge.
    task automatic async_reset();
        #2;
        rst    = 1'b1;
        enable = 1'b0;
        #1;
        model_reset();
        check_all('0, '0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        rst    = 1'b1;
        enable = 1'b0;
        model_reset();
        #12;
        check_all('0, '0);
        @(negedge clk);
        rst = 1'b0;

        // free run: covers first rises at edges 1/2/2/8 and the 16-count wrap
        for (int i = 0; i < 40; i++) step(1'b1);

        // hold enable low for 3 cycles while the divide-by-4 counter sits at 1
        while (edges[1] % 4 != 1) step(1'b1);
        for (int i = 0; i < 3; i++) step(1'b0);
        for (int i = 0; i < 8; i++) step(1'b1);

        // asynchronous reset in the high phase of the divide-by-4 output
        while (edges[1] % 4 != 3) step(1'b1);
        async_reset();
        for (int i = 0; i < 10; i++) step(1'b1);

        // random enable with occasional mid-period resets
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 49) == 0) async_reset();
            step($urandom_range(0, 3) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
